// File: rtl/div_rate_ctrl.sv
// Rate sequencer for the loadable fractional divider: latches mode/trim requests,
// computes the increment word and applies it only on a divider overflow edge.
module div_rate_ctrl #(
  parameter logic [31:0] BASE_INC     = 32'd85,
  parameter int          FAST_SHIFT   = 4,
  parameter int          TRIM_W       = 8,
  parameter logic [15:0] SYNC_TIMEOUT = 16'd50000
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_req,
  input  logic [1:0]               i_mode,
  input  logic signed [TRIM_W-1:0] i_trim,
  input  logic                     i_div_overflow,
  output logic                     o_div_en,
  output logic                     o_div_load,
  output logic [31:0]              o_div_incriment,
  output logic                     o_busy,
  output logic                     o_ack,
  output logic                     o_err,
  output logic [1:0]               o_mode,
  output logic [2:0]               o_state
);

  // Handshake: i_req is taken on any clock edge where o_busy=0 (state IDLE);
  // a valid request ends with exactly one o_ack pulse, an invalid one with one o_err pulse.

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_WAIT = 3'd2,
    ST_LOAD = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [1:0] MODE_RUN  = 2'd0;
  localparam logic [1:0] MODE_FAST = 2'd1;
  localparam logic [1:0] MODE_STOP = 2'd2;
  localparam logic [1:0] MODE_BAD  = 2'd3;

  // Two guard bits keep BASE_INC + 1 + trim exact for any BASE_INC value.
  localparam int SW = 34;
  localparam int FW = SW + FAST_SHIFT;
  localparam logic [SW-1:0] ONE_S = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [FW-1:0] ONE_F = {{(FW-1){1'b0}}, 1'b1};

  state_t                    state_q, state_n;
  logic [1:0]                mode_q, req_mode_q;
  logic                      en_q;
  logic                      err_q;
  logic [31:0]               word_q;
  logic signed [TRIM_W-1:0]  trim_q;
  logic [15:0]               cnt_q;
  logic                      accept;
  logic                      reject;

  logic signed [SW-1:0]      step_s;
  logic [SW-1:0]             step_u;
  logic [SW-1:0]             run_wide;
  logic [FW-1:0]             fast_wide;
  logic [31:0]               run_word;
  logic [31:0]               fast_word;
  logic [31:0]               new_word;

  assign accept = (state_q == ST_IDLE) && i_req && (i_mode != MODE_BAD);
  assign reject = (state_q == ST_IDLE) && i_req && (i_mode == MODE_BAD);

  always_comb begin
    step_s    = $signed({2'b00, BASE_INC}) + $signed(ONE_S)
              + $signed({{(SW-TRIM_W){trim_q[TRIM_W-1]}}, trim_q});
    step_u    = (step_s[SW-1] || (step_s == '0)) ? ONE_S : step_s;
    run_wide  = step_u - ONE_S;
    fast_wide = ({{FAST_SHIFT{1'b0}}, step_u} << FAST_SHIFT) - ONE_F;
    run_word  = (|run_wide[SW-1:32]) ? 32'hFFFF_FFFF : run_wide[31:0];
    fast_word = (|fast_wide[FW-1:32]) ? 32'hFFFF_FFFF : fast_wide[31:0];
    new_word  = (req_mode_q == MODE_FAST) ? fast_word : run_word;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_INIT: state_n = ST_IDLE;
      ST_IDLE: if (accept) state_n = ST_WAIT;
      // A stopped divider never overflows, so leave after a single cycle.
      ST_WAIT: if (!en_q || i_div_overflow || (cnt_q == SYNC_TIMEOUT))
                 state_n = (req_mode_q == MODE_STOP) ? ST_DONE : ST_LOAD;
      ST_LOAD: state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_INIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= ST_INIT;
      mode_q     <= MODE_RUN;
      req_mode_q <= MODE_RUN;
      en_q       <= 1'b0;
      err_q      <= 1'b0;
      word_q     <= BASE_INC;
      trim_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_n;
      err_q   <= reject;
      if (state_q == ST_INIT) begin
        en_q   <= 1'b1;
        mode_q <= MODE_RUN;
      end
      if (accept) begin
        req_mode_q <= i_mode;
        trim_q     <= i_trim;
        cnt_q      <= '0;
      end
      if (state_q == ST_WAIT) cnt_q <= cnt_q + 16'd1;
      if (state_n == ST_LOAD) word_q <= new_word;
      // Enable and mode change only together with the ack.
      if (state_n == ST_DONE) begin
        mode_q <= req_mode_q;
        en_q   <= (req_mode_q != MODE_STOP);
      end
    end
  end

  // Strobes are masked while reset is held so the reset cycle shows no load or ack.
  assign o_div_load      = i_reset_n && ((state_q == ST_INIT) || (state_q == ST_LOAD));
  assign o_ack           = i_reset_n && (state_q == ST_DONE);
  assign o_err           = i_reset_n && err_q;
  assign o_busy          = !i_reset_n || (state_q != ST_IDLE);
  assign o_div_en        = en_q;
  assign o_mode          = mode_q;
  assign o_div_incriment = word_q;
  assign o_state         = state_q;

endmodule
